// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan controller: loads a 14-bit binary value, converts it to BCD
// serially, and swaps it into the scanned display only at a frame boundary.
module fnd_scan_controller #(
  parameter int P_TICK_DIV = 100_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic        i_blankLz,
  input  logic        i_dispOn,
  output logic        o_ready,
  output logic [1:0]  o_digitSelect,
  output logic        o_digitEn,
  output logic [3:0]  o_bcd,
  output logic        o_ovf
);

  localparam int PW = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(P_TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, WAIT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    digit;
  logic          tick;
  logic          frame_end;
  logic [13:0]   bin_sr;
  logic [15:0]   bcd_sr;
  logic [15:0]   bcd_adj;
  logic [3:0]    step_cnt;
  logic          ovf_pend;
  logic [15:0]   disp;
  logic          ovf_r;
  logic          lz_blank;

  function automatic logic [13:0] clamp_9999(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int n = 0; n < 4; n++) begin
      r[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
    end
    return r;
  endfunction

  assign tick      = (pre_cnt == PRE_LAST);
  assign frame_end = tick && (digit == 2'd3);
  assign bcd_adj   = dabble_adjust(bcd_sr);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_cnt <= '0;
      digit   <= 2'd0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) digit <= digit + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_load) state_nxt = CONV;
      CONV:    if (step_cnt == 4'd13) state_nxt = WAIT;
      WAIT:    if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion and commit: one shift per CONV cycle, commit only on a frame boundary.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      step_cnt <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_load) begin
          bin_sr   <= clamp_9999(i_value);
          bcd_sr   <= '0;
          step_cnt <= '0;
          ovf_pend <= (i_value > 14'd9999);
        end
        CONV: begin
          {bcd_sr, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
          step_cnt         <= step_cnt + 4'd1;
        end
        WAIT: if (frame_end) begin
          disp  <= bcd_sr;
          ovf_r <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lz_blank = 1'b0;
    case (digit)
      2'd1:    lz_blank = (disp[15:4] == 12'd0);
      2'd2:    lz_blank = (disp[15:8] == 8'd0);
      2'd3:    lz_blank = (disp[15:12] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end

  assign o_ready       = (state == IDLE);
  assign o_digitSelect = digit;
  assign o_bcd         = disp[digit*4 +: 4];
  assign o_digitEn     = !i_dispOn || (i_blankLz && lz_blank);
  assign o_ovf         = ovf_r;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: decimal-arithmetic reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fnd_scan_controller;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        blank = 1'b1;
  logic        disp_on = 1'b1;
  logic        ready;
  logic [1:0]  sel;
  logic        den;
  logic [3:0]  bcd;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  fnd_scan_controller #(.P_TICK_DIV(P)) dut (
    .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load),
    .i_blankLz(blank), .i_dispOn(disp_on), .o_ready(ready),
    .o_digitSelect(sel), .o_digitEn(den), .o_bcd(bcd), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  // Reference model: time counted in clocks, display held as a decimal integer.
  bit m_valid = 0;
  bit m_busy = 0;
  int m_pre = 0, m_dig = 0, m_k = 0;
  int m_pend = 0, m_disp = 0;
  bit m_povf = 0, m_ovf = 0;

  always @(posedge clk) begin
    bit bnd, tk;
    if (rst) begin
      m_valid = 1; m_busy = 0; m_pre = 0; m_dig = 0; m_k = 0;
      m_disp = 0; m_ovf = 0; m_pend = 0; m_povf = 0;
    end else if (m_valid) begin
      tk  = (m_pre == P - 1);
      bnd = tk && (m_dig == 3);
      if (!m_busy) begin
        if (load) begin
          m_busy = 1; m_k = 0;
          m_pend = (int'(value) > 9999) ? 9999 : int'(value);
          m_povf = (int'(value) > 9999);
        end
      end else begin
        m_k++;
        if (m_k >= 15 && bnd) begin
          m_disp = m_pend; m_ovf = m_povf; m_busy = 0;
        end
      end
      m_pre = tk ? 0 : m_pre + 1;
      if (tk) m_dig = (m_dig + 1) % 4;
    end
  end

  always @(negedge clk) begin
    int exp_en;
    if (m_valid) begin
      exp_en = (!disp_on) ? 1 :
               (blank && m_dig != 0 && m_disp < pow10(m_dig)) ? 1 : 0;
      chk("ready", ready, !m_busy);
      chk("digit_select", sel, m_dig);
      chk("bcd", bcd, (m_disp / pow10(m_dig)) % 10);
      chk("digit_en", den, exp_en);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (ready !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", ready, 1);
  endtask

  task automatic do_load(input int v);
    wait_ready(100);
    value = 14'(v);
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic expect_digit(input int s, input int exp_bcd, input int exp_en);
    int n = 0;
    while (sel !== 2'(s) && n < 40) begin
      step();
      n++;
    end
    chk("sel_reached", sel, s);
    chk("lit_bcd", bcd, exp_bcd);
    chk("lit_en", den, exp_en);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", ready, 1);
    chk("rst_sel", sel, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Blank display after reset: only the ones digit lit.
    expect_digit(0, 0, 0);
    expect_digit(1, 0, 1);
    expect_digit(2, 0, 1);
    expect_digit(3, 0, 1);

    do_load(1234);
    chk("busy_after_load", ready, 0);
    wait_ready(100);
    expect_digit(0, 4, 0);
    expect_digit(1, 3, 0);
    expect_digit(2, 2, 0);
    expect_digit(3, 1, 0);
    chk("ovf_1234", ovf, 0);

    do_load(12000);
    wait_ready(100);
    chk("ovf_12000", ovf, 1);
    expect_digit(0, 9, 0);
    expect_digit(3, 9, 0);

    do_load(7);
    wait_ready(100);
    chk("ovf_7", ovf, 0);
    expect_digit(0, 7, 0);
    expect_digit(1, 0, 1);
    expect_digit(3, 0, 1);

    // Loads while busy are dropped.
    do_load(5678);
    repeat (3) step();
    value = 14'd42; load = 1'b1; step(); load = 1'b0;
    repeat (10) step();
    value = 14'd42; load = 1'b1; step(); load = 1'b0;
    wait_ready(100);
    expect_digit(0, 8, 0);
    expect_digit(1, 7, 0);
    expect_digit(2, 6, 0);
    expect_digit(3, 5, 0);
    repeat (80) step();
    chk("still_5678_ready", ready, 1);
    expect_digit(0, 8, 0);

    // Reset mid-conversion aborts the commit.
    do_load(4321);
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_ovf", ovf, 0);
    chk("abort_sel", sel, 0);
    chk("abort_bcd", bcd, 0);
    repeat (60) step();
    expect_digit(3, 0, 1);

    do_load(8888);
    wait_ready(100);
    disp_on = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("disp_off_en", den, 1);
    end
    disp_on = 1'b1;
    #1;
    chk("disp_on_restore", den, 0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      load  = ($urandom_range(0, 5) == 0);
      value = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) value = 14'($urandom_range(0, 120));
      if ($urandom_range(0, 60) == 0) blank = ~blank;
      if ($urandom_range(0, 80) == 0) disp_on = ~disp_on;
      rst = ($urandom_range(0, 300) == 0);
      step();
    end
    load = 1'b0;
    rst  = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter: P_TICK_DIV, 100_000, clock cycles per digit slot; legal range >= 1.
REQ-003 Port: i_clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port: i_reset  input  1  synchronous, active-high reset.
REQ-005 Port: i_value  input  14  binary value to display (0..16383).
REQ-006 Port: i_load  input  1  load request; accepted only on a cycle where o_ready=1.
REQ-007 Port: i_blankLz  input  1  leading-zero blanking enable.
REQ-008 Port: i_dispOn  input  1  display enable; 0 blanks all digits.
REQ-009 Port: o_ready  output  1  1 when idle and able to accept a load.
REQ-010 Port: o_digitSelect  output  2  index of the scanned digit; 0 is ones, 3 is thousands.
REQ-011 Port: o_digitEn  output  1  digit-decoder blank control; 1 turns all digits off.
REQ-012 Port: o_bcd  output  4  BCD value of the digit selected by o_digitSelect.
REQ-013 Port: o_ovf  output  1  1 when the last committed value exceeded 9999.

Function
REQ-014 Prescaler SHALL count 0..P_TICK_DIV-1 and wrap; tick SHALL be the cycle where count = P_TICK_DIV-1.
REQ-015 Digit counter SHALL increment on each tick, wrapping 3->0; o_digitSelect SHALL equal the digit counter.
REQ-016 Frame boundary SHALL be a tick while the digit counter = 3.
REQ-017 FSM states SHALL be IDLE, CONV and WAIT; o_ready SHALL be 1 exactly in IDLE.
REQ-018 IDLE->CONV on i_load=1; i_value SHALL be sampled on that edge, clamped to 9999 if > 9999, and the ovf flag SHALL be captured.
REQ-019 CONV SHALL run a sequential shift-add-3 (double-dabble) binary-to-BCD conversion for exactly 14 cycles, then enter WAIT.
REQ-020 WAIT SHALL stay until a frame boundary, then on that edge load the 16-bit display register and o_ovf, and return to IDLE.
REQ-021 The updated display SHALL start at digit 0, so a frame never mixes old and new digits.
REQ-022 i_load while o_ready=0 SHALL be ignored, with no queuing; i_value SHALL be ignored outside acceptance.
REQ-023 o_bcd SHALL be the display-register nibble indexed by the digit counter (nibble 0 = ones).
REQ-024 o_digitEn SHALL be 1 if i_dispOn=0; it SHALL also be 1 if i_blankLz=1 and every nibble at index >= the current digit is zero, except at digit 0.
REQ-025 Otherwise o_digitEn SHALL be 0.
REQ-026 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-027 Scanning, prescaler and digit counter SHALL run continuously, independent of FSM state and i_dispOn.
REQ-028 o_digitSelect, o_bcd and o_digitEn SHALL be combinational from registered state plus i_dispOn and i_blankLz only.

Reset
REQ-029 On i_reset=1 at a clock edge: prescaler 0, digit counter 0, FSM IDLE, display register 0x0000, o_ovf 0, conversion registers 0.
REQ-030 In the cycle after that edge: o_ready=1, o_digitSelect=0, o_bcd=0.
REQ-031 Reset in CONV or WAIT SHALL abort the conversion without committing it.
REQ-032 i_reset SHALL have priority over i_load on the same edge.

Verification (bench uses P_TICK_DIV=4)
REQ-033 Reset, i_blankLz=1, i_dispOn=1 -> o_digitSelect cycles 0..3 every 4 clk; digit 0 shows o_bcd=0 with o_digitEn=0; digits 1-3 have o_digitEn=1.
REQ-034 Load 1234 -> o_ready low 14 clk + wait to boundary; next frame shows sel0/bcd4, sel1/bcd3, sel2/bcd2, sel3/bcd1, each 4 clk; o_ovf=0.
REQ-035 Load 12000 -> committed display 9999 and o_ovf=1; a following load of 7 -> displays 7, o_ovf=0, digits 1-3 blanked with i_blankLz=1.
REQ-036 Load 5678, then pulse i_load with 42 during CONV and during WAIT -> display commits 5678 only; o_ready returns to 1 after commit.
REQ-037 Assert i_reset during CONV for a load of 4321 -> next cycle o_ready=1, display 0000, o_ovf=0, no later commit of 4321.
REQ-038 i_dispOn=0 with display 8888 -> o_digitEn=1 on all four digits while o_digitSelect continues cycling; returning i_dispOn to 1 restores digits immediately.
